// File: rtl/gpu_mem_arbiter.sv
// Two-requester arbiter for the shared triple-lane data memory port (datapath vs host/display).
// Round-robin on contention, pipeline stall generation, 1-cycle read return, grant statistics.
module gpu_mem_arbiter #(
    parameter int unsigned DW    = 18,
    parameter int unsigned AW    = 10,
    parameter int unsigned LANES = 3,
    parameter int unsigned CW    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  GpuReq,
    input  logic                  GpuWe,
    input  logic [LANES*AW-1:0]   GpuA,
    input  logic [LANES*DW-1:0]   GpuWd,
    output logic                  GpuStall,
    output logic                  GpuRValid,
    output logic [LANES*DW-1:0]   GpuRd,
    input  logic                  HostReq,
    input  logic                  HostWe,
    input  logic [AW-1:0]         HostA,
    input  logic [LANES*DW-1:0]   HostWd,
    output logic                  HostGnt,
    output logic                  HostRValid,
    output logic [LANES*DW-1:0]   HostRd,
    output logic [LANES*AW-1:0]   MemA,
    output logic                  MemWe,
    output logic [LANES*DW-1:0]   MemWd,
    input  logic [LANES*DW-1:0]   MemRd,
    output logic [CW-1:0]         GntCntGpu,
    output logic [CW-1:0]         GntCntHost
);

    typedef enum logic [1:0] {TagNone, TagGpu, TagHost} tag_e;

    logic          gpu_grant;
    logic          host_grant;
    logic          last_host_q, last_host_d;
    tag_e          tag_q, tag_d;
    logic [CW-1:0] cnt_gpu_q, cnt_gpu_d;
    logic [CW-1:0] cnt_host_q, cnt_host_d;

    // last_host_q = 1 means the host won most recently, so the GPU wins the next contest.
    always_comb begin
        gpu_grant  = 1'b0;
        host_grant = 1'b0;
        if (!RST) begin
            if (GpuReq && (!HostReq || last_host_q)) begin
                gpu_grant = 1'b1;
            end else if (HostReq) begin
                host_grant = 1'b1;
            end
        end
    end

    always_comb begin
        MemA  = '0;
        MemWd = '0;
        MemWe = 1'b0;
        if (gpu_grant) begin
            MemA  = GpuA;
            MemWd = GpuWd;
            MemWe = GpuWe;
        end else if (host_grant) begin
            MemA  = {LANES{HostA}};
            MemWd = HostWd;
            MemWe = HostWe;
        end
    end

    assign GpuStall = GpuReq & ~gpu_grant;
    assign HostGnt  = host_grant;

    // Gated by RST so a read accepted just before reset never returns during it.
    assign GpuRValid  = !RST && (tag_q == TagGpu);
    assign HostRValid = !RST && (tag_q == TagHost);
    assign GpuRd      = GpuRValid  ? MemRd : '0;
    assign HostRd     = HostRValid ? MemRd : '0;

    assign GntCntGpu  = cnt_gpu_q;
    assign GntCntHost = cnt_host_q;

    always_comb begin
        last_host_d = last_host_q;
        tag_d       = TagNone;
        cnt_gpu_d   = cnt_gpu_q;
        cnt_host_d  = cnt_host_q;
        if (gpu_grant) begin
            last_host_d = 1'b0;
            if (!GpuWe) begin
                tag_d = TagGpu;
            end
            if (cnt_gpu_q != '1) begin
                cnt_gpu_d = cnt_gpu_q + 1'b1;
            end
        end
        if (host_grant) begin
            last_host_d = 1'b1;
            if (!HostWe) begin
                tag_d = TagHost;
            end
            if (cnt_host_q != '1) begin
                cnt_host_d = cnt_host_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_host_q <= 1'b1;
            tag_q       <= TagNone;
            cnt_gpu_q   <= '0;
            cnt_host_q  <= '0;
        end else begin
            last_host_q <= last_host_d;
            tag_q       <= tag_d;
            cnt_gpu_q   <= cnt_gpu_d;
            cnt_host_q  <= cnt_host_d;
        end
    end

`ifndef SYNTHESIS
    a_one_grant: assert property (@(posedge CLK) !(gpu_grant && host_grant))
        else $error("both requesters granted");
    a_stall_bound: assert property (@(posedge CLK) disable iff (RST) GpuStall |=> !GpuStall)
        else $error("GpuStall held for two cycles");
`endif

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: reset, single/contested grants, host write,
// reset during read return, idle port and counter saturation.
module tb_gpu_mem_arbiter;

    localparam int unsigned DW    = 18;
    localparam int unsigned AW    = 10;
    localparam int unsigned LANES = 3;
    localparam int unsigned CW    = 16;

    logic                CLK = 1'b0;
    logic                RST;
    logic                GpuReq, GpuWe;
    logic [LANES*AW-1:0] GpuA;
    logic [LANES*DW-1:0] GpuWd;
    logic                GpuStall, GpuRValid;
    logic [LANES*DW-1:0] GpuRd;
    logic                HostReq, HostWe;
    logic [AW-1:0]       HostA;
    logic [LANES*DW-1:0] HostWd;
    logic                HostGnt, HostRValid;
    logic [LANES*DW-1:0] HostRd;
    logic [LANES*AW-1:0] MemA;
    logic                MemWe;
    logic [LANES*DW-1:0] MemWd;
    logic [LANES*DW-1:0] MemRd;
    logic [CW-1:0]       GntCntGpu, GntCntHost;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    gpu_mem_arbiter #(.DW(DW), .AW(AW), .LANES(LANES), .CW(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .GpuReq     (GpuReq),
        .GpuWe      (GpuWe),
        .GpuA       (GpuA),
        .GpuWd      (GpuWd),
        .GpuStall   (GpuStall),
        .GpuRValid  (GpuRValid),
        .GpuRd      (GpuRd),
        .HostReq    (HostReq),
        .HostWe     (HostWe),
        .HostA      (HostA),
        .HostWd     (HostWd),
        .HostGnt    (HostGnt),
        .HostRValid (HostRValid),
        .HostRd     (HostRd),
        .MemA       (MemA),
        .MemWe      (MemWe),
        .MemWd      (MemWd),
        .MemRd      (MemRd),
        .GntCntGpu  (GntCntGpu),
        .GntCntHost (GntCntHost)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    logic [LANES*DW-1:0] rd_pat [5];
    logic                exp_gpu_v;

    initial begin
        rd_pat[0] = {18'h00011, 18'h00022, 18'h00033};
        rd_pat[1] = {18'h3ABCD, 18'h01234, 18'h2FFFF};
        rd_pat[2] = {18'h15555, 18'h2AAAA, 18'h00001};
        rd_pat[3] = {18'h00F0F, 18'h3F0F0, 18'h10000};
        rd_pat[4] = {18'h00777, 18'h00888, 18'h00999};

        RST = 1'b1; GpuReq = 1'b1; GpuWe = 1'b0; GpuA = '0; GpuWd = '0;
        HostReq = 1'b0; HostWe = 1'b0; HostA = '0; HostWd = '0; MemRd = '0;

        // Reset state
        next_cyc(); #3;
        check_val("rst_stall", GpuStall, 1);
        check_val("rst_hostgnt", HostGnt, 0);
        check_val("rst_memwe", MemWe, 0);
        check_val("rst_gpurv", GpuRValid, 0);
        check_val("rst_hostrv", HostRValid, 0);
        next_cyc(); #3;
        check_val("rst_cntgpu", GntCntGpu, 0);
        check_val("rst_cnthost", GntCntHost, 0);

        // Single GPU read
        next_cyc();
        RST = 1'b0; GpuReq = 1'b1; GpuWe = 1'b0; GpuA = {10'd5, 10'd6, 10'd4};
        #3;
        check_val("t1_stall", GpuStall, 0);
        check_val("t1_mema", MemA, {10'd5, 10'd6, 10'd4});
        check_val("t1_memwe", MemWe, 0);
        next_cyc();
        GpuReq = 1'b0; MemRd = rd_pat[0];
        #3;
        check_val("t1_gpurv", GpuRValid, 1);
        check_val("t1_gpurd", GpuRd, rd_pat[0]);
        check_val("t1_hostrv", HostRValid, 0);
        check_val("t1_hostrd", HostRd, 0);
        check_val("t1_cntgpu", GntCntGpu, 1);
        // Idle port
        check_val("idle_memwe", MemWe, 0);
        check_val("idle_mema", MemA, 0);
        check_val("idle_memwd", MemWd, 0);
        check_val("idle_stall", GpuStall, 0);
        check_val("idle_hostgnt", HostGnt, 0);
        next_cyc(); #3;
        check_val("idle_gpurv", GpuRValid, 0);
        check_val("idle_hostrv", HostRValid, 0);
        check_val("idle_gpurd", GpuRd, 0);

        // Contested reads after reset: GPU, HOST, GPU, HOST
        next_cyc(); RST = 1'b1;
        next_cyc();
        RST = 1'b0; GpuReq = 1'b1; HostReq = 1'b1; GpuWe = 1'b0; HostWe = 1'b0;
        HostA = 10'd7; GpuA = {10'd1, 10'd2, 10'd3};
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                GpuReq = 1'b0; HostReq = 1'b0;
            end
            MemRd = rd_pat[k];
            #3;
            if (k < 4) begin
                check_val($sformatf("rr_stall%0d", k), GpuStall, (k % 2 == 1));
                check_val($sformatf("rr_hostgnt%0d", k), HostGnt, (k % 2 == 1));
            end
            if (k > 0) begin
                exp_gpu_v = ((k - 1) % 2 == 0);
                check_val($sformatf("rr_gpurv%0d", k), GpuRValid, exp_gpu_v);
                check_val($sformatf("rr_hostrv%0d", k), HostRValid, !exp_gpu_v);
                check_val($sformatf("rr_gpurd%0d", k), GpuRd, exp_gpu_v ? rd_pat[k] : '0);
                check_val($sformatf("rr_hostrd%0d", k), HostRd, exp_gpu_v ? '0 : rd_pat[k]);
            end
            next_cyc();
        end
        check_val("rr_cntgpu", GntCntGpu, 2);
        check_val("rr_cnthost", GntCntHost, 2);

        // Host write
        HostReq = 1'b1; HostWe = 1'b1; HostA = 10'd100; HostWd = {18'd1, 18'd2, 18'd3};
        #3;
        check_val("hw_gnt", HostGnt, 1);
        check_val("hw_memwe", MemWe, 1);
        check_val("hw_mema", MemA, {10'd100, 10'd100, 10'd100});
        check_val("hw_memwd", MemWd, {18'd1, 18'd2, 18'd3});
        check_val("hw_stall", GpuStall, 0);
        next_cyc();
        HostReq = 1'b0; HostWe = 1'b0;
        #3;
        check_val("hw_hostrv", HostRValid, 0);
        check_val("hw_gpurv", GpuRValid, 0);
        check_val("hw_cnthost", GntCntHost, 3);

        // GPU read then reset: no return in the reset cycle
        next_cyc();
        GpuReq = 1'b1; GpuWe = 1'b0;
        #3;
        check_val("rm_stall", GpuStall, 0);
        next_cyc();
        RST = 1'b1; GpuReq = 1'b0; MemRd = rd_pat[3];
        #3;
        check_val("rm_gpurv", GpuRValid, 0);
        check_val("rm_gpurd", GpuRd, 0);
        next_cyc(); #3;
        check_val("rm_cntgpu", GntCntGpu, 0);
        check_val("rm_cnthost", GntCntHost, 0);
        next_cyc();
        RST = 1'b0; GpuReq = 1'b1; HostReq = 1'b1;
        #3;
        check_val("rm_last_stall", GpuStall, 0);
        check_val("rm_last_hostgnt", HostGnt, 0);

        // Saturation of the GPU grant counter
        next_cyc();
        RST = 1'b1; HostReq = 1'b0; GpuReq = 1'b1;
        next_cyc();
        RST = 1'b0;
        repeat (65534) @(posedge CLK);
        #4;
        check_val("sat_65534", GntCntGpu, 65534);
        @(posedge CLK); #4;
        check_val("sat_65535", GntCntGpu, 65535);
        repeat (5) @(posedge CLK);
        #4;
        check_val("sat_hold", GntCntGpu, 65535);
        check_val("sat_host", GntCntHost, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
